uc_sequencer_n: RTL and testbench
=================================

Name: uc_sequencer_n

Overview:
Parametrised next-generation microprogram sequencer for the microcoded Sigma CPU. Each clock it selects the next microcode ROM address from one of these sources:
- incremented uPC
- a pipeline-register branch field
- the instruction map ROM
- a return stack
Beyond plain jump/call/return it adds condition-tested branches, calls and returns, a loop counter, a stall input and sticky stack-error flags. It sits between the microcode pipeline register and the CodeROM address input.

Parameters:
AW, 12, microcode address width
DEPTH, 4, return stack depth (entries, >=2)
NCOND, 8, number of condition inputs (power of 2)
CW, 8, loop counter width (CW <= AW)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
op  in  4  sequencer opcode from pipeline
src_sel  in  1  target source: 0 = din, 1 = map_addr
din  in  AW  branch target / counter load value from pipeline
map_addr  in  AW  instruction map ROM output
cond  in  NCOND  condition flags (CC bits, ALU zero, etc.)
cond_sel  in  log2(NCOND)  selects condition bit
cond_pol  in  1  1 = invert selected condition
stall  in  1  1 = hold all state this cycle
uc_address  out  AW  current uPC, drives CodeROM address
sp  out  log2(DEPTH)+1  stack occupancy
cnt_zero  out  1  loop counter == 0
stack_ovf  out  1  sticky overflow flag
stack_unf  out  1  sticky underflow flag

Behaviour:
- Reset: while reset==0 at a rising edge:
  - uPC=0, sp=0, counter=0, stack_ovf=0, stack_unf=0.
  - Stack contents are don't-care.
  - Reset overrides stall and op.
- Timing:
  - All state is registered. uc_address is the uPC register itself, with no combinational path from inputs.
  - A new op takes effect on uc_address one clock later.
- Definitions:
  - tgt = src_sel ? map_addr : din.
  - inc = (uPC+1) mod 2^AW. 2^AW-1 wraps to 0.
  - ct = cond[cond_sel] XOR cond_pol.
- stall==1: uPC, stack, sp, counter and flags all hold; op is ignored.
- Opcodes:
  - 0 NEXT: uPC<=inc.
  - 1 JUMP: uPC<=tgt.
  - 2 CALL: push inc; uPC<=tgt.
  - 3 RET: pop; uPC<=top.
  - 4 JCOND: uPC<= ct ? tgt : inc.
  - 5 CCALL: if ct, act as CALL, else NEXT.
  - 6 CRET: if ct, act as RET, else NEXT.
  - 7 LDCNT: counter<=din[CW lsbs]; uPC<=inc. src_sel is ignored.
  - 8 LOOP: if counter!=0, then counter<=counter-1 and uPC<=tgt; else uPC<=inc. The counter never wraps below 0.
  - 9 DISPATCH: uPC<=map_addr regardless of src_sel.
  - 10-15: reserved, behave as NEXT.
- Stack: LIFO of DEPTH entries.
  - Push writes entry[sp] and increments sp.
  - Pop returns entry[sp-1] and decrements sp.
- Overflow: a push with sp==DEPTH still takes the branch. The push is discarded, sp is unchanged and stack_ovf<=1.
- Underflow: a pop with sp==0 sets uPC<=inc, leaves sp at 0 and sets stack_unf<=1.
- Error flags clear only on reset.
- Conditional ops with ct false do not touch stack or flags.
- cnt_zero is combinational from the counter register.
- Reset mid-call-chain discards all stack contents.

Test Plan:
- Reset held low 3 cycles with op=JUMP din=0x055 -> uc_address=0, sp=0, flags 0. Release, issue 4 NEXT -> uc_address 1,2,3,4.
- JUMP din=0x100, then CALL din=0x200, RET -> uc_address 0x100, 0x200, 0x101; sp 0→1→0.
- DEPTH=4: 5 nested CALLs to 0x010..0x014 -> sp=4, stack_ovf=1 after 5th, uc_address=0x014. Then 4 RETs return correctly. A 5th RET -> stack_unf=1, uPC=inc.
- LDCNT din=3, then LOOP din=0x040 repeatedly -> branches 3 times (counter 2,1,0), 4th LOOP falls through to inc, cnt_zero=1.
- cond=0x04, cond_sel=2, cond_pol=0, JCOND din=0x0AA -> taken. Same with cond_pol=1 -> uPC=inc. CCALL with ct false -> sp unchanged.
- uPC=0xFFF, NEXT -> 0x000. DISPATCH with map_addr=0x3C0, src_sel=0 -> 0x3C0. stall=1 during CALL -> uc_address and sp unchanged.

Source files
------------

// File: rtl/uc_sequencer_n.sv
// Microprogram sequencer: picks the next CodeROM address from the incremented uPC,
// a pipeline branch target, the map ROM or a return stack. Also provides
// condition-tested ops, a loop counter, a stall input and sticky stack error flags.
module uc_sequencer_n #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCOND = 8,
  parameter int unsigned CW    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 op,
  input  logic                       src_sel,
  input  logic [AW-1:0]              din,
  input  logic [AW-1:0]              map_addr,
  input  logic [NCOND-1:0]           cond,
  input  logic [$clog2(NCOND)-1:0]   cond_sel,
  input  logic                       cond_pol,
  input  logic                       stall,
  output logic [AW-1:0]              uc_address,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       cnt_zero,
  output logic                       stack_ovf,
  output logic                       stack_unf
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned SPW = PW + 1;
  localparam logic [SPW-1:0] DepthSp = SPW'(DEPTH);

  typedef enum logic [3:0] {
    OpNext     = 4'd0,
    OpJump     = 4'd1,
    OpCall     = 4'd2,
    OpRet      = 4'd3,
    OpJcond    = 4'd4,
    OpCcall    = 4'd5,
    OpCret     = 4'd6,
    OpLdcnt    = 4'd7,
    OpLoop     = 4'd8,
    OpDispatch = 4'd9
  } op_e;

  logic [AW-1:0]  upc_q, upc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic [AW-1:0]  tgt, inc;
  logic           ct;
  logic [SPW-1:0] sp_m1;
  logic [PW-1:0]  wr_idx, rd_idx;
  logic           push_req, pop_req, push_en;

  assign tgt    = src_sel ? map_addr : din;
  assign inc    = upc_q + 1'b1;
  assign ct     = cond[cond_sel] ^ cond_pol;
  assign sp_m1  = sp_q - 1'b1;
  assign wr_idx = sp_q[PW-1:0];
  assign rd_idx = sp_m1[PW-1:0];

  // Next-state decode: opcode selects the uPC source and requests stack pushes/pops.
  always_comb begin
    upc_d    = upc_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    push_en  = 1'b0;
    if (!stall) begin
      upc_d = inc;
      case (op)
        OpJump:     upc_d = tgt;
        OpCall: begin
          push_req = 1'b1;
          upc_d    = tgt;
        end
        OpRet:      pop_req = 1'b1;
        OpJcond:    upc_d = ct ? tgt : inc;
        OpCcall: begin
          if (ct) begin
            push_req = 1'b1;
            upc_d    = tgt;
          end
        end
        OpCret:     pop_req = ct;
        OpLdcnt:    cnt_d = din[CW-1:0];
        OpLoop: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            upc_d = tgt;
          end
        end
        OpDispatch: upc_d = map_addr;
        default:    upc_d = inc;
      endcase

      // A push into a full stack still branches but the return address is lost.
      if (push_req) begin
        if (sp_q == DepthSp) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + 1'b1;
        end
      end

      // A pop from an empty stack falls through to the next address.
      if (pop_req) begin
        if (sp_q == '0) begin
          unf_d = 1'b1;
          upc_d = inc;
        end else begin
          upc_d = stack_q[rd_idx];
          sp_d  = sp_m1;
        end
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      upc_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return stack storage; contents are don't-care after reset since sp is cleared.
  always_ff @(posedge clock) begin
    if (reset && push_en) begin
      stack_q[wr_idx] <= inc;
    end
  end

  assign uc_address = upc_q;
  assign sp         = sp_q;
  assign cnt_zero   = (cnt_q == '0);
  assign stack_ovf  = ovf_q;
  assign stack_unf  = unf_q;

endmodule

// File: tb/tb_uc_sequencer_n.sv
// Directed bench for uc_sequencer_n: stimulus pushes hand-computed expectations into a
// queue, a monitor pops one entry per clock and compares against the DUT outputs.
module tb_uc_sequencer_n;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        src_sel;
  logic [11:0] din;
  logic [11:0] map_addr;
  logic [7:0]  cond;
  logic [2:0]  cond_sel;
  logic        cond_pol;
  logic        stall;
  logic [11:0] uc_address;
  logic [2:0]  sp;
  logic        cnt_zero;
  logic        stack_ovf;
  logic        stack_unf;

  typedef struct packed {
    logic [11:0] pc;
    logic [2:0]  sp;
    logic        cz;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   step_n = 0;

  uc_sequencer_n dut (
    .clock      (clock),
    .reset      (reset),
    .op         (op),
    .src_sel    (src_sel),
    .din        (din),
    .map_addr   (map_addr),
    .cond       (cond),
    .cond_sel   (cond_sel),
    .cond_pol   (cond_pol),
    .stall      (stall),
    .uc_address (uc_address),
    .sp         (sp),
    .cnt_zero   (cnt_zero),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  always #5 clock = ~clock;

  // Monitor: one expectation per clock edge that had stimulus applied.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      step_n++;
      if (uc_address !== e.pc || sp !== e.sp || cnt_zero !== e.cz ||
          stack_ovf !== e.ovf || stack_unf !== e.unf) begin
        n_miss++;
        $display("FAIL vec%0d: got pc=%03h sp=%0d cz=%b ovf=%b unf=%b, want pc=%03h sp=%0d cz=%b ovf=%b unf=%b",
                 step_n, uc_address, sp, cnt_zero, stack_ovf, stack_unf,
                 e.pc, e.sp, e.cz, e.ovf, e.unf);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input logic rst_n, input logic stl, input logic [3:0] o,
                      input logic [11:0] d, input logic [11:0] epc, input logic [2:0] esp,
                      input logic ecz, input logic eovf, input logic eunf);
    exp_t e;
    @(negedge clock);
    reset = rst_n;
    stall = stl;
    op    = o;
    din   = d;
    e.pc  = epc;
    e.sp  = esp;
    e.cz  = ecz;
    e.ovf = eovf;
    e.unf = eunf;
    exp_q.push_back(e);
  endtask

  localparam logic [3:0] NEXT = 4'd0, JUMP = 4'd1, CALL = 4'd2, RET = 4'd3, JCOND = 4'd4,
                         CCALL = 4'd5, CRET = 4'd6, LDCNT = 4'd7, LOOP = 4'd8, DISP = 4'd9;

  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    op       = JUMP;
    src_sel  = 1'b0;
    din      = 12'h055;
    map_addr = 12'h000;
    cond     = 8'h00;
    cond_sel = 3'd0;
    cond_pol = 1'b0;

    // Reset held with a JUMP presented.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, JUMP, 12'h055, 12'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, NEXT, 12'h000, 12'(i), 3'd0, 1'b1, 1'b0, 1'b0);

    // Jump, call, return.
    step(1'b1, 1'b0, JUMP, 12'h100, 12'h100, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, CALL, 12'h200, 12'h200, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h101, 3'd0, 1'b1, 1'b0, 1'b0);

    // Nest five calls into a four-deep stack.
    step(1'b1, 1'b0, CALL, 12'h010, 12'h010, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, CALL, 12'h011, 12'h011, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, CALL, 12'h012, 12'h012, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, CALL, 12'h013, 12'h013, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, CALL, 12'h014, 12'h014, 3'd4, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h013, 3'd3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h012, 3'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h011, 3'd1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h102, 3'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h103, 3'd0, 1'b1, 1'b1, 1'b1);

    // Loop counter.
    step(1'b1, 1'b0, LDCNT, 12'h003, 12'h104, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, LOOP,  12'h040, 12'h040, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, LOOP,  12'h040, 12'h040, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, LOOP,  12'h040, 12'h040, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, LOOP,  12'h040, 12'h041, 3'd0, 1'b1, 1'b1, 1'b1);

    // Conditional ops.
    cond = 8'h04; cond_sel = 3'd2; cond_pol = 1'b0;
    step(1'b1, 1'b0, JCOND, 12'h0AA, 12'h0AA, 3'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clock); cond_pol = 1'b1;
    exp_q.push_back({12'h0AA, 3'd0, 1'b1, 1'b1, 1'b1});
    op = NEXT; din = 12'h000; stall = 1'b1;
    step(1'b1, 1'b0, JCOND, 12'h0AA, 12'h0AB, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, CCALL, 12'h300, 12'h0AC, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, CRET,  12'h000, 12'h0AD, 3'd0, 1'b1, 1'b1, 1'b1);
    cond_pol = 1'b0;
    step(1'b1, 1'b0, CCALL, 12'h300, 12'h300, 3'd1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, CRET,  12'h000, 12'h0AE, 3'd0, 1'b1, 1'b1, 1'b1);

    // Wrap, dispatch, stall, source select.
    step(1'b1, 1'b0, JUMP, 12'hFFF, 12'hFFF, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, NEXT, 12'h000, 12'h000, 3'd0, 1'b1, 1'b1, 1'b1);
    map_addr = 12'h3C0; src_sel = 1'b0;
    step(1'b1, 1'b0, DISP, 12'h123, 12'h3C0, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, CALL, 12'h200, 12'h3C0, 3'd0, 1'b1, 1'b1, 1'b1);
    map_addr = 12'h555; src_sel = 1'b1;
    step(1'b1, 1'b0, JUMP,  12'h123, 12'h555, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, LDCNT, 12'h005, 12'h556, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, LOOP,  12'h040, 12'h556, 3'd0, 1'b0, 1'b1, 1'b1);
    src_sel = 1'b0;

    // Reset in the middle of a call chain, then a return must underflow.
    step(1'b1, 1'b0, CALL, 12'h020, 12'h020, 3'd1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, CALL, 12'h030, 12'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, RET,  12'h000, 12'h001, 3'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd12, 12'h7FF, 12'h002, 3'd0, 1'b1, 1'b0, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
